// File: rtl/pic16_pkg.sv
// Shared PIC16-style core definitions: instruction phases, fetch sequencer states
// and opcode match constants used by the fetch/decode front end.
package pic16_pkg;

    localparam int IR_W = 14;
    localparam int PC_W = 11;

    // Four clocks make one instruction cycle; Q4 is the commit phase.
    localparam logic [1:0] Q1 = 2'd0;
    localparam logic [1:0] Q2 = 2'd1;
    localparam logic [1:0] Q3 = 2'd2;
    localparam logic [1:0] Q4 = 2'd3;

    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_SKIP = 2'd1,
        S_EXEC = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic incr;
        logic jump;
        logic push;
        logic pop;
        logic retfie;
    } strobe_t;

    localparam logic [IR_W-1:0] OP_GOTO_MASK    = 14'h3800;
    localparam logic [IR_W-1:0] OP_GOTO_MATCH   = 14'h2800;
    localparam logic [IR_W-1:0] OP_CALL_MASK    = 14'h3800;
    localparam logic [IR_W-1:0] OP_CALL_MATCH   = 14'h2000;
    localparam logic [IR_W-1:0] OP_RETURN       = 14'h0008;
    localparam logic [IR_W-1:0] OP_RETFIE       = 14'h0009;
    localparam logic [IR_W-1:0] OP_RETLW_MASK   = 14'h3C00;
    localparam logic [IR_W-1:0] OP_RETLW_MATCH  = 14'h3400;
    localparam logic [IR_W-1:0] OP_DECFSZ_MASK  = 14'h3F00;
    localparam logic [IR_W-1:0] OP_DECFSZ_MATCH = 14'h0B00;
    localparam logic [IR_W-1:0] OP_INCFSZ_MASK  = 14'h3F00;
    localparam logic [IR_W-1:0] OP_INCFSZ_MATCH = 14'h0F00;
    localparam logic [IR_W-1:0] OP_BTFSC_MASK   = 14'h3C00;
    localparam logic [IR_W-1:0] OP_BTFSC_MATCH  = 14'h1800;
    localparam logic [IR_W-1:0] OP_BTFSS_MASK   = 14'h3C00;
    localparam logic [IR_W-1:0] OP_BTFSS_MATCH  = 14'h1C00;

    function automatic logic op_match(input logic [IR_W-1:0] word,
                                      input logic [IR_W-1:0] mask,
                                      input logic [IR_W-1:0] match);
        return (word & mask) == match;
    endfunction

endpackage

// File: rtl/instr_branch_decode.sv
// Classifies the instruction register into the control-flow groups that the
// fetch sequencer cares about: jumps, calls, returns and conditional skips.
module instr_branch_decode
    import pic16_pkg::*;
(
    input  logic [IR_W-1:0] ir,
    output logic            is_goto,
    output logic            is_call,
    output logic            is_return,
    output logic            is_retfie,
    output logic            is_skip,
    output logic            is_branch
);

    logic is_retlw;
    logic is_decfsz;
    logic is_incfsz;
    logic is_btfsc;
    logic is_btfss;

    always_comb begin
        is_goto   = op_match(ir, OP_GOTO_MASK, OP_GOTO_MATCH);
        is_call   = op_match(ir, OP_CALL_MASK, OP_CALL_MATCH);
        is_retfie = (ir == OP_RETFIE);
        is_retlw  = op_match(ir, OP_RETLW_MASK, OP_RETLW_MATCH);
        is_decfsz = op_match(ir, OP_DECFSZ_MASK, OP_DECFSZ_MATCH);
        is_incfsz = op_match(ir, OP_INCFSZ_MASK, OP_INCFSZ_MATCH);
        is_btfsc  = op_match(ir, OP_BTFSC_MASK, OP_BTFSC_MATCH);
        is_btfss  = op_match(ir, OP_BTFSS_MASK, OP_BTFSS_MATCH);
        // All three return flavours pop the hardware stack the same way.
        is_return = (ir == OP_RETURN) || is_retfie || is_retlw;
        is_skip   = is_decfsz || is_incfsz || is_btfsc || is_btfss;
        is_branch = is_goto || is_call || is_return;
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Four-phase fetch/execute sequencer: owns the instruction register, decides
// whether the fetched word executes, and issues the program-counter strobes.
module fetch_sequencer
    import pic16_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [IR_W-1:0] instr_in,
    input  logic            skip_cond,
    input  logic            pcl_wr_in,
    output logic            pc_incr_en,
    output logic            pc_j_en,
    output logic            pc_j_and_push_en,
    output logic            pc_j_by_pop_en,
    output logic [PC_W-1:0] pc_j_addr,
    output logic [IR_W-1:0] ir_out,
    output logic            ir_valid,
    output logic [1:0]      q_phase,
    output logic            retfie_pulse
);

    logic [1:0]      q_phase_q;
    logic [1:0]      q_phase_d;
    seq_state_e      state_q;
    seq_state_e      state_d;
    logic [IR_W-1:0] ir_q;
    logic [IR_W-1:0] ir_d;

    logic    is_goto;
    logic    is_call;
    logic    is_return;
    logic    is_retfie;
    logic    is_skip;
    logic    is_branch;
    logic    end_of_cycle;
    logic    exec_q4;
    strobe_t strobe;

    instr_branch_decode u_decode (
        .ir        (ir_q),
        .is_goto   (is_goto),
        .is_call   (is_call),
        .is_return (is_return),
        .is_retfie (is_retfie),
        .is_skip   (is_skip),
        .is_branch (is_branch)
    );

    assign end_of_cycle = (q_phase_q == Q4);
    assign exec_q4      = end_of_cycle && (state_q == S_EXEC);

    always_comb begin
        q_phase_d = q_phase_q + 2'd1;
        ir_d      = ir_q;
        state_d   = state_q;
        if (end_of_cycle) begin
            ir_d    = instr_in;
            state_d = S_EXEC;
            // A redirect flushes the stale prefetch; a taken skip discards it but keeps counting.
            if (state_q == S_EXEC) begin
                if (is_branch || pcl_wr_in) begin
                    state_d = S_HOLD;
                end else if (is_skip && skip_cond) begin
                    state_d = S_SKIP;
                end
            end
        end
    end

    always_comb begin
        strobe      = '0;
        strobe.incr = (q_phase_q == Q1) && (state_q != S_HOLD);
        if (exec_q4) begin
            if (is_goto) begin
                strobe.jump = 1'b1;
            end else if (is_call) begin
                strobe.push = 1'b1;
            end else if (is_return) begin
                strobe.pop = 1'b1;
            end
            strobe.retfie = is_retfie;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_phase_q <= Q1;
            state_q   <= S_HOLD;
            ir_q      <= '0;
        end else begin
            q_phase_q <= q_phase_d;
            state_q   <= state_d;
            ir_q      <= ir_d;
        end
    end

    assign q_phase          = q_phase_q;
    assign ir_out           = ir_q;
    assign ir_valid         = (state_q == S_EXEC);
    assign pc_j_addr        = ir_q[PC_W-1:0];
    assign pc_incr_en       = strobe.incr;
    assign pc_j_en          = strobe.jump;
    assign pc_j_and_push_en = strobe.push;
    assign pc_j_by_pop_en   = strobe.pop;
    assign retfie_pulse     = strobe.retfie;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a program memory with PC and call stack feeds the DUT,
// and an instruction-cycle model predicts every output on every falling edge.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic [13:0] instr_in;
    logic        skip_cond;
    logic        pcl_wr_in;
    logic        pc_incr_en;
    logic        pc_j_en;
    logic        pc_j_and_push_en;
    logic        pc_j_by_pop_en;
    logic [10:0] pc_j_addr;
    logic [13:0] ir_out;
    logic        ir_valid;
    logic [1:0]  q_phase;
    logic        retfie_pulse;

    int tests_run;
    int tests_failed;

    logic [13:0] mem      [0:2047];
    bit          skip_tab [0:2047];
    bit          pcl_tab  [0:2047];
    logic [10:0] pc;
    logic [10:0] ir_addr;
    logic [10:0] stack [$];

    logic [1:0]  cap_phase;
    logic        cap_incr, cap_jump, cap_push, cap_pop;
    logic [10:0] cap_addr;

    int          m_phase;
    bit          m_valid;
    bit          m_incr;
    logic [13:0] m_ir;

    bit          directed;
    int          trace [$];
    int          goto_addr_seen, call_addr_seen, retfie_count, skip_flush_count;

    fetch_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .instr_in         (instr_in),
        .skip_cond        (skip_cond),
        .pcl_wr_in        (pcl_wr_in),
        .pc_incr_en       (pc_incr_en),
        .pc_j_en          (pc_j_en),
        .pc_j_and_push_en (pc_j_and_push_en),
        .pc_j_by_pop_en   (pc_j_by_pop_en),
        .pc_j_addr        (pc_j_addr),
        .ir_out           (ir_out),
        .ir_valid         (ir_valid),
        .q_phase          (q_phase),
        .retfie_pulse     (retfie_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign instr_in = mem[pc];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Q4 gets the per-address table value; other phases get noise the DUT must ignore.
    task automatic applyStimulus();
        if (q_phase == 2'd3) begin
            skip_cond = skip_tab[ir_addr];
            pcl_wr_in = pcl_tab[ir_addr];
        end else begin
            skip_cond = 1'($urandom_range(0, 1));
            pcl_wr_in = 1'($urandom_range(0, 1));
        end
    endtask

    function automatic void classify(input logic [13:0] w, output bit g, output bit c,
                                     output bit r, output bit f, output bit s);
        int hi3, hi4, hi6, v;
        v   = int'(w);
        hi3 = v / 2048;
        hi4 = v / 1024;
        hi6 = v / 256;
        g = (hi3 == 5);
        c = (hi3 == 4);
        f = (v == 9);
        r = (v == 8) || (v == 9) || (hi4 == 13);
        s = (hi6 == 11) || (hi6 == 15) || (hi4 == 6) || (hi4 == 7);
    endfunction

    function automatic logic [13:0] randomInstr();
        logic [13:0] w;
        case ($urandom_range(0, 15))
            0:       w = 14'h2800 | 14'($urandom_range(0, 2047));
            1:       w = 14'h2000 | 14'($urandom_range(0, 2047));
            2:       w = 14'h0008;
            3:       w = 14'h0009;
            4:       w = 14'h3400 | 14'($urandom_range(0, 255));
            5:       w = 14'h1800 | 14'($urandom_range(0, 1023));
            6:       w = 14'h1C00 | 14'($urandom_range(0, 1023));
            7:       w = 14'h0B00 | 14'($urandom_range(0, 255));
            8:       w = 14'h0F00 | 14'($urandom_range(0, 255));
            default: w = 14'($urandom_range(0, 16383));
        endcase
        return w;
    endfunction

    always @(negedge clk) begin
        cap_phase = q_phase;
        cap_incr  = pc_incr_en;
        cap_jump  = pc_j_en;
        cap_push  = pc_j_and_push_en;
        cap_pop   = pc_j_by_pop_en;
        cap_addr  = pc_j_addr;
    end

    // Program counter and 8-deep return stack driven by the DUT strobes.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= '0;
            ir_addr <= '0;
            stack.delete();
        end else begin
            if (cap_phase == 2'd3) ir_addr <= pc;
            if (cap_incr) begin
                pc <= pc + 11'd1;
            end else if (cap_jump) begin
                pc <= cap_addr;
            end else if (cap_push) begin
                if (stack.size() == 8) void'(stack.pop_front());
                stack.push_back(pc);
                pc <= cap_addr;
            end else if (cap_pop) begin
                pc <= (stack.size() > 0) ? stack.pop_back() : 11'd0;
            end
        end
    end

    // Instruction-cycle model: each cycle either executes its word or is a flush,
    // with or without the Q1 increment; decided from the word committed last cycle.
    always @(negedge clk) begin
        bit g, c, r, f, s, q4x;
        if (!rst) begin
            checkOutput("rst_q_phase", 32'(q_phase), 0);
            checkOutput("rst_ir_out", 32'(ir_out), 0);
            checkOutput("rst_ir_valid", 32'(ir_valid), 0);
            checkOutput("rst_strobes", {27'd0, pc_incr_en, pc_j_en, pc_j_and_push_en,
                                        pc_j_by_pop_en, retfie_pulse}, 0);
            checkOutput("rst_pc_j_addr", 32'(pc_j_addr), 0);
            m_phase = 1;
            m_valid = 1'b0;
            m_incr  = 1'b0;
            m_ir    = '0;
        end else begin
            classify(m_ir, g, c, r, f, s);
            q4x = (m_phase == 3) && m_valid;
            checkOutput("q_phase", 32'(q_phase), 32'(m_phase));
            checkOutput("ir_out", 32'(ir_out), 32'(m_ir));
            checkOutput("ir_valid", 32'(ir_valid), 32'(m_valid));
            checkOutput("pc_incr_en", 32'(pc_incr_en), 32'((m_phase == 0) && m_incr));
            checkOutput("pc_j_en", 32'(pc_j_en), 32'(q4x && g));
            checkOutput("pc_j_and_push_en", 32'(pc_j_and_push_en), 32'(q4x && c));
            checkOutput("pc_j_by_pop_en", 32'(pc_j_by_pop_en), 32'(q4x && r));
            checkOutput("retfie_pulse", 32'(retfie_pulse), 32'(q4x && f));
            checkOutput("pc_j_addr", 32'(pc_j_addr), 32'(m_ir) % 2048);

            if (directed) begin
                if (pc_j_en && goto_addr_seen < 0) goto_addr_seen = int'(pc_j_addr);
                if (pc_j_and_push_en && call_addr_seen < 0) call_addr_seen = int'(pc_j_addr);
                if (retfie_pulse) retfie_count++;
                if (q_phase == 2'd0 && pc_incr_en && !ir_valid) skip_flush_count++;
                if (q_phase == 2'd3 && ir_valid) trace.push_back(int'(ir_addr));
            end

            if (m_phase == 3) begin
                if (m_valid && (g || c || r || pcl_wr_in)) begin
                    m_valid = 1'b0;
                    m_incr  = 1'b0;
                end else if (m_valid && s && skip_cond) begin
                    m_valid = 1'b0;
                    m_incr  = 1'b1;
                end else begin
                    m_valid = 1'b1;
                    m_incr  = 1'b1;
                end
                m_ir = instr_in;
            end
            m_phase = (m_phase + 1) % 4;
        end
    end

    initial begin
        skip_cond = 1'b0;
        pcl_wr_in = 1'b0;
        @(negedge clk);
        forever begin
            @(posedge clk);
            #1;
            applyStimulus();
        end
    end

    initial begin
        int  exp_trace [14];
        bit  found;
        tests_run        = 0;
        tests_failed     = 0;
        directed         = 1'b0;
        goto_addr_seen   = -1;
        call_addr_seen   = -1;
        retfie_count     = 0;
        skip_flush_count = 0;
        exp_trace = '{0, 1, 2, 3, 16, 17, 4, 5, 7, 8, 9, 32, 10, 11};
        rst = 1'b0;

        for (int a = 0; a < 2048; a++) begin
            mem[a]      = 14'h0000;
            skip_tab[a] = 1'b0;
            pcl_tab[a]  = 1'b0;
        end
        mem[3]     = 14'h2010;
        mem[4]     = 14'h2805;
        mem[5]     = 14'h1C03;
        mem[7]     = 14'h1C03;
        mem[9]     = 14'h2020;
        mem[11]    = 14'h280B;
        mem[16]    = 14'h0000;
        mem[17]    = 14'h0008;
        mem[32]    = 14'h0009;
        skip_tab[5] = 1'b1;
        skip_tab[7] = 1'b0;
        pcl_tab[10] = 1'b1;

        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 checkOutput("release_q_phase", 32'(q_phase), 0);
        directed = 1'b1;
        repeat (32 * 4) @(negedge clk);
        directed = 1'b0;

        checkOutput("trace_len_ok", 32'(trace.size() >= 14), 1);
        for (int i = 0; i < 14; i++) begin
            if (i < trace.size()) checkOutput("exec_trace", 32'(trace[i]), 32'(exp_trace[i]));
        end
        checkOutput("goto_target", 32'(goto_addr_seen), 32'h005);
        checkOutput("call_target", 32'(call_addr_seen), 32'h010);
        checkOutput("retfie_count", 32'(retfie_count), 1);
        checkOutput("skip_flush_count", 32'(skip_flush_count), 1);

        // Reset in the middle of Q3 of the looping GOTO: the Q4 jump must never appear.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (q_phase == 2'd2 && ir_valid) found = 1'b1;
        end
        checkOutput("goto_q3_found", 32'(found), 1);
        checkOutput("goto_q3_ir", 32'(ir_out), 32'h280B);
        #2 rst = 1'b0;
        #1;
        checkOutput("midrst_q_phase", 32'(q_phase), 0);
        checkOutput("midrst_ir_valid", 32'(ir_valid), 0);
        checkOutput("midrst_ir_out", 32'(ir_out), 0);
        checkOutput("midrst_strobes", {27'd0, pc_incr_en, pc_j_en, pc_j_and_push_en,
                                       pc_j_by_pop_en, retfie_pulse}, 0);
        checkOutput("midrst_pc_j_addr", 32'(pc_j_addr), 0);
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1 checkOutput("midrst_release_q_phase", 32'(q_phase), 0);
        repeat (10 * 4) @(negedge clk);

        // Randomized program with random skip results and PCL writes.
        #2 rst = 1'b0;
        for (int a = 0; a < 2048; a++) begin
            mem[a]      = randomInstr();
            skip_tab[a] = 1'($urandom_range(0, 1));
            pcl_tab[a]  = ($urandom_range(0, 7) == 0);
        end
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        repeat (3000 * 4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
